// File: rtl/elastic_pipe_reg.sv
// Multi-stage valid/ready pipeline register with global enable and synchronous flush.
// Latency: DEPTH cycles from input transfer to out_valid when out_ready is held high; 1 word/cycle.
// Backpressure: empty stages collapse bubbles; in_ready falls only when all DEPTH stages hold words
// and out_ready=0, and combinationally follows out_ready through the stage-advance chain.
//
// Parameters:
//   L      data width in bits (>=1)
//   DEPTH  number of register stages (>=1)
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset (clears stage valids only)
//   ena        global advance enable; 0 freezes every stage
//   flush      synchronous flush of all stages
//   in_valid   upstream word valid
//   in_ready   block accepts d this cycle
//   d          upstream data
//   out_valid  q holds a valid word
//   out_ready  downstream accepts q this cycle
//   q          last-stage data
//   count      occupied stages, present only when PIPE_REG_COUNT_EN is defined
// Optional feature macro: PIPE_REG_COUNT_EN (adds the count port and its counter).
module elastic_pipe_reg #(
  parameter int L     = 24,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [L-1:0]                 d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [L-1:0]                 q
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   count
`endif
);

  if (DEPTH < 1) begin : g_depth_check
    $error("elastic_pipe_reg: DEPTH must be at least 1");
  end

  // Stage 0 is the input side, stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [L-1:0]     r [DEPTH];

  // A stage may advance if it is empty or anything in front of it can move.
  // That is equivalent to: out_ready, or some stage at or beyond i is empty.
  // Walking from the output backwards with a running OR keeps each adv bit
  // a plain function of v/out_ready (no feedback through the adv vector).
  // This is the intended out_ready -> in_ready combinational path.
  always_comb begin
    logic run;
    run = out_ready;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run    = run | ~v[i];
      adv[i] = run;
    end
  end

  assign in_ready  = ena & ~flush & adv[0];
  assign out_valid = v[DEPTH-1];
  assign q         = r[DEPTH-1];

  // Valid bits: reset and flush win over enable; stalled stages hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else if (ena) begin
      if (adv[0]) begin
        v[0] <= in_valid;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
        end
      end
    end
  end

  // Data registers carry no reset; they load only when a real word moves in,
  // so a bubble passing through never disturbs held data.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && ena) begin
      if (adv[0] && in_valid) begin
        r[0] <= d;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i] && v[i-1]) begin
          r[i] <= r[i-1];
        end
      end
    end
  end

`ifdef PIPE_REG_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt;
  logic          in_xfer;
  logic          out_xfer;

  // An output transfer only counts while the pipe is allowed to move.
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready & ena & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt <= '0;
    end else if (in_xfer && !out_xfer) begin
      cnt <= cnt + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign count = cnt;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
module tb_elastic_pipe_reg;

  localparam int L = 24;
  localparam int NI = 3;
  localparam int DEP [NI] = '{2, 3, 4};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          flush;
  logic          in_valid;
  logic [L-1:0]  d;
  logic          out_ready;
  logic          ir [NI];
  logic          ov [NI];
  logic [L-1:0]  qq [NI];
  logic [1:0]    c2;
  logic [1:0]    c3;
  logic [2:0]    c4;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.L(L), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .d(d),
    .out_valid(ov[0]), .out_ready(out_ready), .q(qq[0])
`ifdef PIPE_REG_COUNT_EN
    , .count(c2)
`endif
  );

  elastic_pipe_reg #(.L(L), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .d(d),
    .out_valid(ov[1]), .out_ready(out_ready), .q(qq[1])
`ifdef PIPE_REG_COUNT_EN
    , .count(c3)
`endif
  );

  elastic_pipe_reg #(.L(L), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .d(d),
    .out_valid(ov[2]), .out_ready(out_ready), .q(qq[2])
`ifdef PIPE_REG_COUNT_EN
    , .count(c4)
`endif
  );

  // Reference model: per pipe, the list of held words (oldest first), each
  // with its stage position. Each cycle the oldest leaves if it sits at the
  // last stage and out_ready is high; every other word moves one stage on
  // unless it would collide with the word ahead of it.
  logic [L-1:0] wd [NI][4];
  int           wp [NI][4];
  int           wn [NI];
  int           np_s [NI][4];

  function automatic bit plan(input int k);
    int lim;
    int j0;
    bit pop;
    pop = (wn[k] > 0) && (wp[k][0] == DEP[k] - 1) && out_ready;
    lim = DEP[k];
    j0  = pop ? 1 : 0;
    for (int j = 0; j < 4; j++) np_s[k][j] = 0;
    for (int j = j0; j < wn[k]; j++) begin
      int n;
      n = wp[k][j] + 1;
      if (n > lim - 1) n = lim - 1;
      np_s[k][j] = n;
      lim = n;
    end
    return pop;
  endfunction

  function automatic bit exp_ir(input int k);
    bit pop;
    bit room;
    if (!ena || flush) return 1'b0;
    if (wn[k] == 0) return 1'b1;
    pop = plan(k);
    if (pop && wn[k] == 1) room = 1'b1;
    else room = (np_s[k][wn[k]-1] > 0);
    return room;
  endfunction

  function automatic int get_cnt(input int k);
    if (k == 0) return int'(c2);
    if (k == 1) return int'(c3);
    return int'(c4);
  endfunction

  task automatic model_update(input int k);
    bit acc;
    bit pop;
    int m;
    if (!rst_n || flush) begin
      wn[k] = 0;
    end else if (ena) begin
      acc = exp_ir(k) && in_valid;
      pop = plan(k);
      m = 0;
      for (int j = (pop ? 1 : 0); j < wn[k]; j++) begin
        wd[k][m] = wd[k][j];
        wp[k][m] = np_s[k][j];
        m++;
      end
      if (acc) begin
        wd[k][m] = d;
        wp[k][m] = 0;
        m++;
      end
      wn[k] = m;
    end
  endtask

  task automatic check_inst(input int k, input string tag);
    bit           eov;
    bit           eir;
    logic [L-1:0] eq;
    eov = (wn[k] > 0) && (wp[k][0] == DEP[k] - 1);
    eq  = wd[k][0];
    checks++;
    assert (ov[k] === eov) else begin
      failures++;
      $error("FAIL %s d%0d out_valid got=%0b exp=%0b", tag, DEP[k], ov[k], eov);
    end
    if (eov) begin
      checks++;
      assert (qq[k] === eq) else begin
        failures++;
        $error("FAIL %s d%0d q got=%h exp=%h", tag, DEP[k], qq[k], eq);
      end
    end
    if (rst_n) begin
      eir = exp_ir(k);
      checks++;
      assert (ir[k] === eir) else begin
        failures++;
        $error("FAIL %s d%0d in_ready got=%0b exp=%0b", tag, DEP[k], ir[k], eir);
      end
    end
`ifdef PIPE_REG_COUNT_EN
    checks++;
    assert (get_cnt(k) === wn[k]) else begin
      failures++;
      $error("FAIL %s d%0d count got=%0d exp=%0d", tag, DEP[k], get_cnt(k), wn[k]);
    end
`endif
  endtask

  // Inputs are changed just after a falling edge; outputs are sampled 1 time
  // unit later and the model advances on the following rising edge.
  task automatic tick(input string tag);
    #1;
    if (started) begin
      for (int k = 0; k < NI; k++) check_inst(k, tag);
    end
    @(posedge clk);
    started = 1;
    for (int k = 0; k < NI; k++) model_update(k);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) wn[k] = 0;

    // T1: reset held with a word offered.
    rst_n = 1'b0; ena = 1'b1; flush = 1'b0;
    in_valid = 1'b1; d = 24'hABCDEF; out_ready = 1'b1;
    tick("t1_rst");
    tick("t1_rst");
    rst_n = 1'b1; in_valid = 1'b0;
    tick("t1_post");

    // T2: single word latency with out_ready high.
    in_valid = 1'b1; d = 24'h000001;
    tick("t2_in");
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick("t2_lat");

    // T3: back-pressure, third word held until accepted.
    out_ready = 1'b0;
    in_valid = 1'b1; d = 24'h000011; tick("t3_w1");
    d = 24'h000022; tick("t3_w2");
    d = 24'h000033;
    for (int i = 0; i < 3; i++) tick("t3_full");
    out_ready = 1'b1; tick("t3_drain");
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick("t3_drain");

    // T4: bubble collapse under stall.
    out_ready = 1'b0;
    in_valid = 1'b1; d = 24'h00005A; tick("t4_in");
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick("t4_walk");
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 24'h000060 + L'(i);
      tick("t4_fill");
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick("t4_drain");

    // T5: flush with words in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 24'h000070 + L'(i);
      tick("t5_load");
    end
    flush = 1'b1; d = 24'h000077; tick("t5_flush");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick("t5_after");

    // T6: enable stall while the output is presented.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 24'h000080 + L'(i);
      tick("t6_load");
    end
    ena = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 24'h000090 + L'(i);
      tick("t6_stall");
    end
    ena = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick("t6_resume");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      ena       = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      d         = L'($urandom);
      tick("rand");
    end
    rst_n = 1'b1; flush = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
